// File: rtl/wb_management_bridge_pkg.sv
// -----------------------------------------------------------------------------
// wb_management_bridge_pkg
//   Shared management-bus definitions used by the bridge RTL, its testbench and
//   software: bus widths, the Wishbone window nibble that selects the bridge,
//   the management register offsets and the core window.
// -----------------------------------------------------------------------------
package wb_management_bridge_pkg;

  localparam int unsigned WB_ADR_W   = 24;
  localparam int unsigned WB_DAT_W   = 32;
  localparam int unsigned WB_SEL_W   = 4;
  localparam int unsigned MGMT_ADR_W = 20;

  // Value of wb_adr_i[23:20] that selects the management window.
  localparam logic [3:0] WB_WINDOW_NIBBLE = 4'h0;

  // Management register offsets inside the 1 MiB management window.
  localparam logic [MGMT_ADR_W-1:0] MGMT_REG_0_OFFSET = 20'h00000;
  localparam logic [MGMT_ADR_W-1:0] MGMT_REG_1_OFFSET = 20'h00004;
  localparam logic [MGMT_ADR_W-1:0] MGMT_REG_2_OFFSET = 20'h00008;

  // Core window: management addresses 0x1xxxx (address bits [19:16] == 1).
  localparam logic [3:0] MGMT_CORE_WINDOW = 4'h1;

  function automatic logic in_wb_window(input logic [WB_ADR_W-1:0] adr,
                                        input logic [3:0]          base);
    return adr[WB_ADR_W-1 -: 4] == base;
  endfunction

  function automatic logic is_core_address(input logic [MGMT_ADR_W-1:0] adr);
    return adr[MGMT_ADR_W-1 -: 4] == MGMT_CORE_WINDOW;
  endfunction

endpackage

// File: rtl/wb_management_bridge_if.sv
// -----------------------------------------------------------------------------
// wb_management_bridge_if
//   Wishbone classic bus between a host master and the management bridge.
//   Signal map to the classic names:
//     cyc   -> wb_cyc_i     stb -> wb_stb_i     we  -> wb_we_i
//     sel   -> wb_sel_i     adr -> wb_adr_i     dat_w -> wb_dat_i
//     dat_r -> wb_dat_o     ack -> wb_ack_o     err -> wb_error_o
//   modport master : host side (drives the request, receives the response)
//   modport slave  : bridge side
// -----------------------------------------------------------------------------
interface wb_management_bridge_if;
  import wb_management_bridge_pkg::*;

  logic                cyc;
  logic                stb;
  logic                we;
  logic [WB_SEL_W-1:0] sel;
  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] dat_w;
  logic [WB_DAT_W-1:0] dat_r;
  logic                ack;
  logic                err;

  modport master (output cyc, stb, we, sel, adr, dat_w,
                  input  dat_r, ack, err);

  modport slave  (input  cyc, stb, we, sel, adr, dat_w,
                  output dat_r, ack, err);

endinterface

// File: rtl/wb_management_bridge.sv
// -----------------------------------------------------------------------------
// wb_management_bridge
//   Wishbone classic slave that turns host bus cycles into single-cycle
//   requests on the core management interface. A cycle hitting the window is
//   latched and presented for as long as JTAG owns the management bus; the
//   Wishbone cycle then ends with ack (read data captured) or, after TIMEOUT
//   busy cycles, with error and all-ones data.
//
//   Parameters
//     BASE_ADDRESS : wb_adr_i[23:20] value that selects the bridge
//     TIMEOUT      : busy cycles tolerated before error (0 = wait forever)
//   Ports
//     clk, rst                  : clock, synchronous active-high reset
//     wb                        : Wishbone slave modport
//     wb_management_enable      : request valid (only in REQUEST)
//     wb_management_writeEnable : request is a write
//     wb_management_byteSelect  : latched byte select
//     wb_management_address     : latched wb_adr_i[19:0]
//     wb_management_writeData   : latched write data
//     wb_management_readData    : read data from the management block
//     wb_management_busy        : JTAG owns the bus, request not serviced
// -----------------------------------------------------------------------------
module wb_management_bridge
  import wb_management_bridge_pkg::*;
#(
  parameter logic [3:0]  BASE_ADDRESS = WB_WINDOW_NIBBLE,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_management_bridge_if.slave wb,
  output logic                  wb_management_enable,
  output logic                  wb_management_writeEnable,
  output logic [WB_SEL_W-1:0]   wb_management_byteSelect,
  output logic [MGMT_ADR_W-1:0] wb_management_address,
  output logic [WB_DAT_W-1:0]   wb_management_writeData,
  input  logic [WB_DAT_W-1:0]   wb_management_readData,
  input  logic                  wb_management_busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  // Wide enough to hold TIMEOUT itself; one bit when the timeout is disabled.
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t                state_q;
  logic                  ack_q;
  logic                  err_q;
  logic [WB_DAT_W-1:0]   dat_q;
  logic                  we_q;
  logic [WB_SEL_W-1:0]   sel_q;
  logic [MGMT_ADR_W-1:0] adr_q;
  logic [WB_DAT_W-1:0]   wdat_q;
  logic [CNT_W-1:0]      cnt_q;

  logic hit;
  assign hit = wb.cyc && wb.stb && in_wb_window(wb.adr, BASE_ADDRESS);

  // NOTE: every register here is written with <= so all of them update from
  // the same pre-edge values; a blocking = would let later statements in this
  // block see already-updated state and change the FSM's behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the latched request fields are reset too, even though the
      // outputs are gated by state; it keeps them clean in simulation and is
      // only a few flops, unlike a real memory which should not be reset.
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // Terminations are single-cycle pulses.
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            we_q    <= wb.we;
            sel_q   <= wb.sel;
            adr_q   <= wb.adr[MGMT_ADR_W-1:0];
            wdat_q  <= wb.dat_w;
            cnt_q   <= '0;
            state_q <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (!wb.cyc) begin
            // Master gave up: silently drop the request.
            state_q <= ST_IDLE;
          end else if (!wb_management_busy) begin
            if (!we_q) dat_q <= wb_management_readData;
            ack_q   <= 1'b1;
            state_q <= ST_RESPOND;
          end else if (TIMEOUT != 0 && cnt_q == CNT_LIMIT) begin
            err_q   <= 1'b1;
            dat_q   <= '1;
            state_q <= ST_RESPOND;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESPOND: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb.ack   = ack_q;
  assign wb.err   = err_q;
  assign wb.dat_r = dat_q;

  // Management request is decoded from state only; fields read zero when idle.
  assign wb_management_enable      = (state_q == ST_REQUEST);
  assign wb_management_writeEnable = wb_management_enable & we_q;
  assign wb_management_byteSelect  = {WB_SEL_W{wb_management_enable}} & sel_q;
  assign wb_management_address     = {MGMT_ADR_W{wb_management_enable}} & adr_q;
  assign wb_management_writeData   = {WB_DAT_W{wb_management_enable}} & wdat_q;

endmodule

// File: tb/tb_wb_management_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_management_bridge
//   Two bridges (TIMEOUT=255 and TIMEOUT=4) share one stimulus stream. A
//   transaction-level reference model predicts every output each cycle;
//   directed sequences additionally pin latencies and values to literals.
// -----------------------------------------------------------------------------
module tb_wb_management_bridge;
  import wb_management_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared master stimulus.
  logic        m_cyc, m_stb, m_we;
  logic [3:0]  m_sel;
  logic [23:0] m_adr;
  logic [31:0] m_dat;
  logic        busy;
  logic [31:0] rdata;

  wb_management_bridge_if bus_a ();
  wb_management_bridge_if bus_b ();

  assign bus_a.cyc = m_cyc;  assign bus_b.cyc = m_cyc;
  assign bus_a.stb = m_stb;  assign bus_b.stb = m_stb;
  assign bus_a.we  = m_we;   assign bus_b.we  = m_we;
  assign bus_a.sel = m_sel;  assign bus_b.sel = m_sel;
  assign bus_a.adr = m_adr;  assign bus_b.adr = m_adr;
  assign bus_a.dat_w = m_dat; assign bus_b.dat_w = m_dat;

  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  sel_a, sel_b;
  logic [19:0] adr_a, adr_b;
  logic [31:0] wd_a, wd_b;

  wb_management_bridge #(.BASE_ADDRESS(4'h0), .TIMEOUT(255)) dut_a (
    .clk                      (clk),
    .rst                      (rst),
    .wb                       (bus_a),
    .wb_management_enable     (en_a),
    .wb_management_writeEnable(we_a),
    .wb_management_byteSelect (sel_a),
    .wb_management_address    (adr_a),
    .wb_management_writeData  (wd_a),
    .wb_management_readData   (rdata),
    .wb_management_busy       (busy)
  );

  wb_management_bridge #(.BASE_ADDRESS(4'h0), .TIMEOUT(4)) dut_b (
    .clk                      (clk),
    .rst                      (rst),
    .wb                       (bus_b),
    .wb_management_enable     (en_b),
    .wb_management_writeEnable(we_b),
    .wb_management_byteSelect (sel_b),
    .wb_management_address    (adr_b),
    .wb_management_writeData  (wd_b),
    .wb_management_readData   (rdata),
    .wb_management_busy       (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one pending transaction, how many busy cycles it has
  // waited, and which termination (if any) is being shown this cycle.
  // resp: 0 none, 1 ack, 2 error.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          active;
    int          waited;
    int          resp;
    logic [31:0] dat;
    bit          we;
    logic [3:0]  sel;
    logic [19:0] adr;
    logic [31:0] wd;
  } model_t;

  model_t mdl_a, mdl_b;
  bit     mdl_valid = 1'b0;

  function automatic model_t model_next(input model_t m, input int tmo);
    model_t n = m;
    if (rst) begin
      n = '{default: 0};
    end else if (m.resp != 0) begin
      n.resp = 0;
    end else if (m.active) begin
      if (!m_cyc) begin
        n.active = 1'b0;
      end else if (!busy) begin
        if (!m.we) n.dat = rdata;
        n.resp   = 1;
        n.active = 1'b0;
      end else if (tmo != 0 && m.waited >= tmo) begin
        n.dat    = 32'hFFFF_FFFF;
        n.resp   = 2;
        n.active = 1'b0;
      end else begin
        n.waited = m.waited + 1;
      end
    end else if (m_cyc && m_stb && m_adr[23:20] == WB_WINDOW_NIBBLE) begin
      n.active = 1'b1;
      n.waited = 0;
      n.we     = m_we;
      n.sel    = m_sel;
      n.adr    = m_adr[19:0];
      n.wd     = m_dat;
    end
    return n;
  endfunction

  task automatic compare_dut(input string tag, input model_t m,
                             input logic ack, input logic err, input logic [31:0] dat,
                             input logic en, input logic we, input logic [3:0] sel,
                             input logic [19:0] adr, input logic [31:0] wd);
    check1 ({tag, ".ack"},   ack, m.resp == 1);
    check1 ({tag, ".error"}, err, m.resp == 2);
    check32({tag, ".dat_o"}, dat, m.dat);
    check1 ({tag, ".enable"}, en, m.active);
    check1 ({tag, ".writeEnable"}, we, m.active && m.we);
    check32({tag, ".byteSelect"}, 32'(sel), 32'(m.active ? m.sel : 4'h0));
    check32({tag, ".address"},    32'(adr), 32'(m.active ? m.adr : 20'h0));
    check32({tag, ".writeData"},  wd, m.active ? m.wd : 32'h0);
  endtask

  // Inputs only change just after a rising edge, so at the falling edge they
  // are exactly what the next rising edge will sample.
  always @(negedge clk) begin
    if (mdl_valid) begin
      compare_dut("a", mdl_a, bus_a.ack, bus_a.err, bus_a.dat_r, en_a, we_a, sel_a, adr_a, wd_a);
      compare_dut("b", mdl_b, bus_b.ack, bus_b.err, bus_b.dat_r, en_b, we_b, sel_b, adr_b, wd_b);
    end
    mdl_a = model_next(mdl_a, 255);
    mdl_b = model_next(mdl_b, 4);
    if (rst) mdl_valid = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic we,
                       input logic [23:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    m_cyc = cyc; m_stb = stb; m_we = we; m_adr = adr; m_dat = dat; m_sel = sel;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_cnt, ack_at, b_err_at, b_en_cnt, a_term, b_ack;
    logic [31:0] dat_at_ack, b_dat_at_err;
    logic a_en7, a_en8;
    int busy_pct;

    rst = 1'b1; busy = 1'b0; rdata = 32'h0;
    idle();
    repeat (2) step();
    rst = 1'b0;

    // Reset state.
    mid();
    check1 ("reset.ack",    bus_a.ack, 1'b0);
    check1 ("reset.error",  bus_a.err, 1'b0);
    check32("reset.dat_o",  bus_a.dat_r, 32'h0);
    check1 ("reset.enable", en_a, 1'b0);

    // Uncontended write: enable at N+1, ack at N+2.
    step(); drive(1'b1, 1'b1, 1'b1, 24'h000000, 32'h0000_0005, 4'hF);
    step(); mid();
    check1 ("wr.enable",      en_a, 1'b1);
    check32("wr.address",     32'(adr_a), 32'(MGMT_REG_0_OFFSET));
    check1 ("wr.writeEnable", we_a, 1'b1);
    check32("wr.writeData",   wd_a, 32'h0000_0005);
    check32("wr.byteSelect",  32'(sel_a), 32'hF);
    check1 ("wr.ack_early",   bus_a.ack, 1'b0);
    step(); mid();
    check1 ("wr.ack",    bus_a.ack, 1'b1);
    check1 ("wr.error",  bus_a.err, 1'b0);
    check1 ("wr.enable_after", en_a, 1'b0);
    step(); idle();

    // Uncontended read.
    step(); drive(1'b1, 1'b1, 1'b0, 24'h000004, 32'h0, 4'hF); rdata = 32'hDEAD_BEEF;
    step(); mid();
    check32("rd.address", 32'(adr_a), 32'(MGMT_REG_1_OFFSET));
    check1 ("rd.writeEnable", we_a, 1'b0);
    step(); mid();
    check1 ("rd.ack",   bus_a.ack, 1'b1);
    check32("rd.dat_o", bus_a.dat_r, 32'hDEAD_BEEF);
    check1 ("rd.error", bus_a.err, 1'b0);
    step(); idle();

    // Contended read: busy for the first 10 REQUEST cycles.
    step(); drive(1'b1, 1'b1, 1'b0, 24'h000008, 32'h0, 4'hF); busy = 1'b1; rdata = 32'h1234_5678;
    en_cnt = 0; ack_at = 0; b_err_at = 0; dat_at_ack = '0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 11) busy = 1'b0;
      if (k == 13) idle();
      mid();
      if (en_a) en_cnt++;
      if (bus_a.ack && ack_at == 0) begin ack_at = k; dat_at_ack = bus_a.dat_r; end
      if (bus_b.err && b_err_at == 0) b_err_at = k;
    end
    check32("busy.enable_cycles", 32'(en_cnt), 32'd11);
    check32("busy.ack_cycle",     32'(ack_at), 32'd12);
    check32("busy.dat_o",         dat_at_ack, 32'h1234_5678);
    check32("busy.b_error_cycle", 32'(b_err_at), 32'd6);

    // Timeout on the TIMEOUT=4 bridge, then cyc dropped while the other waits.
    step(); drive(1'b1, 1'b1, 1'b0, 24'h000008, 32'h0, 4'hF); busy = 1'b1;
    b_en_cnt = 0; b_err_at = 0; b_ack = 0; a_term = 0; b_dat_at_err = '0;
    a_en7 = 1'b0; a_en8 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 7) idle();
      mid();
      if (en_b) b_en_cnt++;
      if (bus_b.err && b_err_at == 0) begin b_err_at = k; b_dat_at_err = bus_b.dat_r; end
      if (bus_b.ack) b_ack++;
      if (bus_a.ack || bus_a.err) a_term++;
      if (k == 7) a_en7 = en_a;
      if (k == 8) a_en8 = en_a;
    end
    check32("tmo.b_enable_cycles", 32'(b_en_cnt), 32'd5);
    check32("tmo.b_error_cycle",   32'(b_err_at), 32'd6);
    check32("tmo.b_dat_o",         b_dat_at_err, 32'hFFFF_FFFF);
    check32("tmo.b_ack_count",     32'(b_ack), 32'd0);
    check1 ("abort.enable_held",   a_en7, 1'b1);
    check1 ("abort.enable_dropped", a_en8, 1'b0);
    check32("abort.terminations",  32'(a_term), 32'd0);
    busy = 1'b0;

    // Normal write after the abort.
    step(); drive(1'b1, 1'b1, 1'b1, 24'h00000C, 32'hA5A5_A5A5, 4'h3);
    step(); mid();
    check32("post_abort.writeData", wd_a, 32'hA5A5_A5A5);
    step(); mid();
    check1 ("post_abort.ack", bus_a.ack, 1'b1);
    step(); idle();

    // Reset while in REQUEST.
    step(); drive(1'b1, 1'b1, 1'b0, 24'h010000, 32'h0, 4'hF); busy = 1'b1;
    step(); mid();
    check1 ("rstreq.enable", en_a, 1'b1);
    check1 ("rstreq.core_window", is_core_address(adr_a), 1'b1);
    step(); rst = 1'b1; idle();
    step(); rst = 1'b0; mid();
    check1 ("rstreq.enable_dropped", en_a, 1'b0);
    check1 ("rstreq.ack",   bus_a.ack, 1'b0);
    check1 ("rstreq.error", bus_a.err, 1'b0);
    check32("rstreq.dat_o", bus_a.dat_r, 32'h0);
    busy = 1'b0; rdata = 32'hCAFE_F00D;
    step(); drive(1'b1, 1'b1, 1'b0, 24'h000000, 32'h0, 4'hF);
    step(); step(); mid();
    check1 ("post_rst.ack",   bus_a.ack, 1'b1);
    check32("post_rst.dat_o", bus_a.dat_r, 32'hCAFE_F00D);
    step(); idle();

    // Address outside the window: nothing happens for 20 cycles.
    step(); drive(1'b1, 1'b1, 1'b0, 24'h100000, 32'h0, 4'hF);
    a_term = 0; en_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      step(); mid();
      if (en_a) en_cnt++;
      if (bus_a.ack || bus_a.err) a_term++;
    end
    check32("miss.enable_cycles", 32'(en_cnt), 32'd0);
    check32("miss.terminations",  32'(a_term), 32'd0);
    step(); idle();

    // Randomized traffic checked by the model alone.
    busy_pct = 20;
    for (int c = 0; c < 800; c++) begin
      step();
      if (c % 100 == 0) busy_pct = (busy_pct == 20) ? 90 : 20;
      rst   = ($urandom_range(0, 63) == 0);
      m_cyc = ($urandom_range(0, 7) != 0);
      m_stb = ($urandom_range(0, 3) != 0);
      m_we  = 1'($urandom);
      m_adr = {(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0), 20'($urandom)};
      m_dat = $urandom;
      m_sel = 4'($urandom);
      busy  = ($urandom_range(0, 99) < busy_pct);
      rdata = $urandom;
    end
    rst = 1'b0; busy = 1'b0; idle();
    repeat (4) step();
    mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_management_bridge.md
# wb_management_bridge

Wishbone classic slave that converts processor/host bus cycles into the single-cycle `wb_management_*` request interface of the core management block, directly upstream of it. It decodes the management window, latches each cycle, holds the request while the JTAG master owns the management bus, and returns ack or error with read data. A wait counter bounds how long a Wishbone cycle can be stalled by JTAG arbitration.

## Interface
- `BASE_ADDRESS`, default 4'h0: value of `wb_adr_i[23:20]` that selects this bridge.
- `TIMEOUT`, default 255: maximum busy-wait cycles before an error termination; 0 disables the timeout.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `wb_cyc_i`  in  1  Wishbone cycle.
- `wb_stb_i`  in  1  Wishbone strobe.
- `wb_we_i`  in  1  write enable.
- `wb_sel_i`  in  4  byte select.
- `wb_adr_i`  in  24  byte address.
- `wb_dat_i`  in  32  write data.
- `wb_ack_o`  out  1  one-cycle normal termination.
- `wb_error_o`  out  1  one-cycle error termination (timeout).
- `wb_dat_o`  out  32  read data, valid with ack.
- `wb_management_enable`  out  1  request to management block.
- `wb_management_writeEnable`  out  1  request is a write.
- `wb_management_byteSelect`  out  4  latched `wb_sel_i`.
- `wb_management_address`  out  20  latched `wb_adr_i[19:0]`.
- `wb_management_writeData`  out  32  latched `wb_dat_i`.
- `wb_management_readData`  in  32  combinational read data from management block.
- `wb_management_busy`  in  1  JTAG owns the bus this cycle; request not serviced.

## Operation
- States: IDLE, REQUEST, RESPOND.
- IDLE: when `wb_cyc_i && wb_stb_i && wb_adr_i[23:20]==BASE_ADDRESS`, latch we/sel/adr[19:0]/dat, clear wait counter, go REQUEST. Non-matching cycles ignored (no ack, no error).
- REQUEST: `wb_management_enable`=1 with latched fields; `wb_management_writeEnable`=latched we. All management outputs 0 outside REQUEST.
  - `busy`=0: access performed this cycle; on read, capture `wb_management_readData` into `wb_dat_o`; go RESPOND (ack).
  - `busy`=1: stay; increment counter (width clog2(TIMEOUT+1), saturating). When counter reaches TIMEOUT (TIMEOUT≠0) and still busy: go RESPOND (error), `wb_dat_o`=32'hFFFF_FFFF, no access performed.
  - `wb_cyc_i` low: abort to IDLE, no ack/error, enable dropped same cycle (registered state: enable low next cycle; a cycle with busy=0 already committed the access).
- RESPOND: exactly one of `wb_ack_o`/`wb_error_o` high for one cycle; return to IDLE unconditionally.
- Write data for writes: `wb_dat_o` unchanged from previous value.
- `wb_sel_i`=0 forwarded unchanged; management block decides.

## Timing
- Reset: state IDLE, `wb_ack_o`=0, `wb_error_o`=0, `wb_dat_o`=0, all `wb_management_*` outputs 0, counter 0. Reset mid-transaction drops the request next edge with no termination.
- Uncontended: stb sampled cycle N, enable high N+1, ack N+2. Min 3 cycles per transfer; new cycle accepted no earlier than N+3.
- Contended: ack one cycle after first busy-free REQUEST cycle.
- Timeout: with busy held, error asserted at REQUEST entry + TIMEOUT + 1 cycles.
- Outputs `wb_ack_o`, `wb_error_o`, `wb_dat_o`, state registered; management outputs decoded from state plus latched registers (no input-to-output combinational path except none).

## Structure
- State encodings are local constants. Management address map (register offsets 0x000/0x004/0x008, core window 0x1xxxx) and Wishbone window nibble belong in the shared management definitions package for bench and software use.
- No sub-module; counter and FSM inline.

## Test plan
- Write 0x0000_0005 to adr 0x000000, sel 4'hF, busy=0 -> enable high one cycle with address 0x00000, writeEnable=1, writeData 0x5; ack two cycles after stb.
- Read adr 0x000004 with readData=0xDEAD_BEEF -> `wb_dat_o`=0xDEAD_BEEF with ack, `wb_error_o`=0.
- Read with busy high 10 cycles, TIMEOUT=255 -> enable held 11 cycles, ack on cycle 12 after entry, correct data.
- TIMEOUT=4, busy held constantly -> error after 5 REQUEST cycles, `wb_dat_o`=0xFFFF_FFFF, no ack.
- adr 0x100000 with BASE_ADDRESS=0 -> no enable, no ack, no error for 20 cycles.
- Drop `wb_cyc_i` while busy, and separately assert `rst` in REQUEST -> enable low next cycle, no ack/error, bridge accepts next cycle normally.
